// File: rtl/aabb_leaf_scheduler_if.sv
// rtl/aabb_leaf_scheduler_if.sv - request, primitive-memory, hit-unit and result signals of the leaf scheduler
//
// Groups every non-clock signal of aabb_leaf_scheduler.
//   req_*  : leaf request from the BVH traversal unit (valid/ready)
//   mem_*  : primitive memory read strobe and address
//   hu_*   : hit-unit result for the read issued in the previous cycle
//   res_*  : leaf result back to the traversal unit (valid/ready)
// Modports:
//   slave  : the scheduler itself
//   master : the surrounding traversal unit, memory and hit datapath
interface aabb_leaf_scheduler_if #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 5,
  parameter int T_W   = 32,
  parameter int VI_W  = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             req_any_hit;
  logic [IDX_W-1:0] req_base;
  logic [CNT_W-1:0] req_count;
  logic             mem_rd_en;
  logic [IDX_W-1:0] mem_rd_addr;
  logic             hu_hit;
  logic [T_W-1:0]   hu_t;
  logic [VI_W-1:0]  hu_vi;
  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [T_W-1:0]   res_t;
  logic [VI_W-1:0]  res_vi;

  modport slave (
    input  req_valid, req_any_hit, req_base, req_count,
    output req_ready,
    output mem_rd_en, mem_rd_addr,
    input  hu_hit, hu_t, hu_vi,
    output res_valid, res_hit, res_t, res_vi,
    input  res_ready
  );

  modport master (
    output req_valid, req_any_hit, req_base, req_count,
    input  req_ready,
    input  mem_rd_en, mem_rd_addr,
    output hu_hit, hu_t, hu_vi,
    input  res_valid, res_hit, res_t, res_vi,
    output res_ready
  );
endinterface

// File: rtl/aabb_leaf_scheduler.sv
// rtl/aabb_leaf_scheduler.sv - sequences the shared AABB-hit datapath over one BVH leaf
//
// Accepts a leaf (base address, primitive count, any-hit flag), issues one
// primitive read per cycle, evaluates the hit-unit answer one cycle later,
// keeps the closest hit (or stops at the first one in any-hit mode) and
// returns it over a valid/ready handshake.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : aabb_leaf_scheduler_if.slave (req_*, mem_*, hu_*, res_*)
module aabb_leaf_scheduler #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 5,
  parameter int T_W   = 32,
  parameter int VI_W  = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  aabb_leaf_scheduler_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             any_hit_q;
  logic [IDX_W-1:0] addr;
  logic [CNT_W-1:0] remaining;
  logic             pend;        // a read was issued last cycle; hu_* belongs to it
  logic             best_valid;
  logic [T_W-1:0]   best_t;
  logic [VI_W-1:0]  best_vi;

  logic             accept;
  logic             eval;
  logic             better;
  logic             stop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    accept    = 1'b0;
    eval      = 1'b0;
    better    = 1'b0;
    stop      = 1'b0;
    state_nxt = state;

    accept = (state == S_IDLE) && bus.req_valid;
    eval   = pend && ((state == S_ISSUE) || (state == S_DRAIN));
    // Strict less-than: on equal distance the earlier primitive is kept.
    better = bus.hu_hit && (!best_valid || ($signed(bus.hu_t) < $signed(best_t)));
    // In any-hit mode the first evaluated hit ends the leaf; the read issued
    // in the same cycle is simply never evaluated.
    stop   = eval && any_hit_q && bus.hu_hit;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (bus.req_count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stop) begin
          state_nxt = S_DONE;
        end else if (remaining == CNT_W'(1)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      any_hit_q  <= 1'b0;
      addr       <= '0;
      remaining  <= '0;
      pend       <= 1'b0;
      best_valid <= 1'b0;
      best_t     <= '0;
      best_vi    <= '0;
    end else begin
      if (accept) begin
        any_hit_q  <= bus.req_any_hit;
        addr       <= bus.req_base;
        remaining  <= bus.req_count;
        best_valid <= 1'b0;
      end
      if (state == S_ISSUE) begin
        addr      <= addr + 1'b1;   // wraps modulo 2^IDX_W
        remaining <= remaining - 1'b1;
      end
      // A read issued this cycle is only worth evaluating if we stay busy.
      pend <= (state == S_ISSUE) && (state_nxt != S_DONE);
      if (eval && better) begin
        best_valid <= 1'b1;
        best_t     <= bus.hu_t;
        best_vi    <= bus.hu_vi;
      end
    end
  end

  always_comb begin
    bus.req_ready   = (state == S_IDLE);
    bus.mem_rd_en   = (state == S_ISSUE);
    bus.mem_rd_addr = (state == S_ISSUE) ? addr : '0;
    bus.res_valid   = (state == S_DONE);
    bus.res_hit     = (state == S_DONE) && best_valid;
    bus.res_t       = ((state == S_DONE) && best_valid) ? best_t : '0;
    bus.res_vi      = ((state == S_DONE) && best_valid) ? best_vi : '0;
  end

endmodule

// File: tb/tb_aabb_leaf_scheduler.sv
// tb/tb_aabb_leaf_scheduler.sv - self-checking bench for aabb_leaf_scheduler
//
// Acts as traversal unit, primitive memory and hit unit. Primitive hit data
// lives in per-address tables; a reference model walks the leaf to predict
// the result, latency and read sequence.
module tb_aabb_leaf_scheduler;

  localparam int IDX_W = 10;
  localparam int CNT_W = 5;
  localparam int T_W   = 32;
  localparam int VI_W  = 16;
  localparam int DEPTH = 1 << IDX_W;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  aabb_leaf_scheduler_if #(.IDX_W(IDX_W), .CNT_W(CNT_W), .T_W(T_W), .VI_W(VI_W)) bus ();

  aabb_leaf_scheduler #(.IDX_W(IDX_W), .CNT_W(CNT_W), .T_W(T_W), .VI_W(VI_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  bit              ph [DEPTH];
  logic [T_W-1:0]  pt [DEPTH];
  logic [VI_W-1:0] pv [DEPTH];

  int checks = 0;
  int passes = 0;

  logic             rd_q = 1'b0;
  logic [IDX_W-1:0] rd_addr_q = '0;
  logic [IDX_W-1:0] rd_log [$];

  // Memory + hit unit: reads seen this cycle are answered in the next one.
  always @(negedge clk) begin
    rd_q      = bus.mem_rd_en;
    rd_addr_q = bus.mem_rd_addr;
    if (bus.mem_rd_en) rd_log.push_back(bus.mem_rd_addr);
  end

  always @(posedge clk) begin
    #1;
    if (rd_q) begin
      bus.hu_hit = ph[rd_addr_q];
      bus.hu_t   = pt[rd_addr_q];
      bus.hu_vi  = pv[rd_addr_q];
    end else begin
      bus.hu_hit = 1'($urandom_range(0, 1));
      bus.hu_t   = T_W'($urandom);
      bus.hu_vi  = VI_W'($urandom);
    end
  end

  task automatic set_prim(input logic [IDX_W-1:0] a, input bit h, input logic [T_W-1:0] t,
                          input logic [VI_W-1:0] vi);
    ph[a] = h;
    pt[a] = t;
    pv[a] = vi;
  endtask

  task automatic fill_random(input logic [IDX_W-1:0] base, input int cnt);
    logic [IDX_W-1:0] a;
    int v;
    for (int i = 0; i < cnt; i++) begin
      a = base + IDX_W'(i);
      v = int'($urandom_range(0, 7)) - 4;
      ph[a] = ($urandom_range(0, 2) == 0);
      pt[a] = T_W'(v * 65536 + int'($urandom_range(0, 1)) * 32768);
      pv[a] = VI_W'($urandom);
    end
  endtask

  // Issue one leaf, hold res_ready low for 'hold' cycles of res_valid, then
  // consume the result and compare everything against the reference model.
  task automatic run_req(input bit any, input logic [IDX_W-1:0] base, input int cnt,
                         input int hold, input string name);
    bit               found;
    logic [T_W-1:0]   exp_t;
    logic [VI_W-1:0]  exp_vi;
    int               k;
    int               exp_reads;
    int               exp_lat;
    int               lat;
    logic [IDX_W-1:0] a;
    logic [T_W-1:0]   t0;
    logic [VI_W-1:0]  vi0;
    bit               h0;

    found = 0; exp_t = '0; exp_vi = '0; k = -1;
    for (int i = 0; i < cnt; i++) begin
      a = base + IDX_W'(i);
      if (ph[a] && (!found || $signed(pt[a]) < $signed(exp_t))) begin
        if (!(any && found)) begin
          found = 1; exp_t = pt[a]; exp_vi = pv[a];
          if (k < 0) k = i;
        end
      end
      if (any && found) break;
    end
    if (any && found) begin
      exp_reads = (k + 2 < cnt) ? k + 2 : cnt;
      exp_lat   = k + 3;
    end else begin
      exp_reads = cnt;
      exp_lat   = (cnt == 0) ? 1 : cnt + 2;
    end

    @(negedge clk);
    rd_log.delete();
    bus.res_ready   = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_any_hit = any;
    bus.req_base    = base;
    bus.req_count   = CNT_W'(cnt);
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL %s req_ready idle: got %b want 1", name, bus.req_ready);
    else passes++;
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b0;
    bus.req_base    = IDX_W'($urandom);
    bus.req_count   = CNT_W'($urandom);
    bus.req_any_hit = 1'($urandom_range(0, 1));

    lat = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    else passes++;
    checks++;
    if (bus.res_hit !== found || bus.res_t !== exp_t || bus.res_vi !== exp_vi)
      $display("FAIL %s result: got hit=%b t=%h vi=%h want hit=%b t=%h vi=%h",
               name, bus.res_hit, bus.res_t, bus.res_vi, found, exp_t, exp_vi);
    else passes++;
    checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL %s req_ready busy: got %b want 0", name, bus.req_ready);
    else passes++;

    h0 = bus.res_hit; t0 = bus.res_t; vi0 = bus.res_vi;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.res_hit !== h0 ||
          bus.res_t !== t0 || bus.res_vi !== vi0)
        $display("FAIL %s hold cycle %0d: got valid=%b ready=%b hit=%b t=%h vi=%h want valid=1 ready=0 hit=%b t=%h vi=%h",
                 name, h, bus.res_valid, bus.req_ready, bus.res_hit, bus.res_t, bus.res_vi, h0, t0, vi0);
      else passes++;
    end

    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL %s after handshake: got valid=%b ready=%b want valid=0 ready=1",
               name, bus.res_valid, bus.req_ready);
    else passes++;

    checks++;
    if (rd_log.size() != exp_reads) $display("FAIL %s read count: got %0d want %0d", name, rd_log.size(), exp_reads);
    else passes++;
    for (int i = 0; i < rd_log.size() && i < exp_reads; i++) begin
      checks++;
      if (rd_log[i] !== base + IDX_W'(i))
        $display("FAIL %s read addr %0d: got %h want %h", name, i, rd_log[i], base + IDX_W'(i));
      else passes++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_rd_en !== 1'b0 || bus.mem_rd_addr !== '0 ||
        bus.res_valid !== 1'b0 || bus.res_hit !== 1'b0 || bus.res_t !== '0 || bus.res_vi !== '0)
      $display("FAIL %s outputs: got ready=%b rd_en=%b addr=%h valid=%b hit=%b t=%h vi=%h want 1 0 000 0 0 0 0",
               name, bus.req_ready, bus.mem_rd_en, bus.mem_rd_addr, bus.res_valid, bus.res_hit,
               bus.res_t, bus.res_vi);
    else passes++;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_any_hit = 1'b0; bus.req_base = '0; bus.req_count = '0;
    bus.res_ready = 1'b0; bus.hu_hit = 1'b0; bus.hu_t = '0; bus.hu_vi = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_closest();
    set_prim(10'h010, 1, 32'h0005_0000, 16'd7);
    set_prim(10'h011, 0, 32'h0001_0000, 16'd1);
    set_prim(10'h012, 1, 32'h0002_0000, 16'd9);
    set_prim(10'h013, 1, 32'h0002_0000, 16'd11);
    run_req(0, 10'h010, 4, 0, "closest_plan");
    for (int i = 0; i < 4; i++) begin
      logic [IDX_W-1:0] b;
      int n;
      b = IDX_W'($urandom);
      n = $urandom_range(1, 31);
      fill_random(b, n);
      run_req(0, b, n, 0, "closest_rand");
    end
  endtask

  task automatic test_any_hit();
    set_prim(10'h100, 0, 32'h0001_0000, 16'd1);
    set_prim(10'h101, 1, 32'h0003_0000, 16'd4);
    set_prim(10'h102, 1, 32'h0000_8000, 16'd5);
    set_prim(10'h103, 1, 32'hFFFF_0000, 16'd6);
    set_prim(10'h104, 0, 32'h0000_0000, 16'd0);
    set_prim(10'h105, 1, 32'hFFF0_0000, 16'd8);
    run_req(1, 10'h100, 6, 0, "any_hit_plan");
    set_prim(10'h120, 0, 32'h0, 16'd0);
    set_prim(10'h121, 0, 32'h0, 16'd0);
    set_prim(10'h122, 1, 32'h0004_0000, 16'd3);
    run_req(1, 10'h120, 3, 0, "any_hit_last");
    for (int i = 0; i < 4; i++) begin
      logic [IDX_W-1:0] b;
      int n;
      b = IDX_W'($urandom);
      n = $urandom_range(1, 31);
      fill_random(b, n);
      run_req(1, b, n, 1, "any_hit_rand");
    end
  endtask

  task automatic test_empty_miss();
    run_req(0, 10'h055, 0, 0, "empty");
    run_req(1, 10'h056, 0, 0, "empty_any");
    for (int i = 0; i < 3; i++) set_prim(10'h200 + 10'(i), 0, 32'h0007_0000, 16'd2);
    run_req(0, 10'h200, 3, 0, "all_miss");
  endtask

  task automatic test_wrap_negative();
    set_prim(10'h3FE, 1, 32'hFFFF_0000, 16'd21);
    set_prim(10'h3FF, 1, 32'h0000_8000, 16'd22);
    set_prim(10'h000, 0, 32'h8000_0000, 16'd23);
    run_req(0, 10'h3FE, 3, 0, "wrap_negative");
    set_prim(10'h3FF, 1, 32'h0000_8000, 16'd31);
    set_prim(10'h000, 1, 32'h8000_0000, 16'd32);
    run_req(0, 10'h3FF, 2, 0, "most_negative");
  endtask

  task automatic test_backpressure();
    fill_random(10'h300, 5);
    run_req(0, 10'h300, 5, 5, "backpressure");
    fill_random(10'h310, 2);
    run_req(0, 10'h310, 2, 0, "back_to_back");
  endtask

  task automatic test_reset_mid_issue();
    fill_random(10'h280, 5);
    @(negedge clk);
    rd_log.delete();
    bus.req_valid = 1'b1; bus.req_any_hit = 1'b0; bus.req_base = 10'h280; bus.req_count = 5'd5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 10'h281)
      $display("FAIL mid_issue second read: got en=%b addr=%h want en=1 addr=281", bus.mem_rd_en, bus.mem_rd_addr);
    else passes++;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    check_reset_outputs("async_reset_held");
    resetn = 1'b1;
    set_prim(10'h2A0, 1, 32'h0000_4000, 16'd77);
    run_req(0, 10'h2A0, 1, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [IDX_W-1:0] b;
      int n;
      bit any;
      b = IDX_W'($urandom);
      n = $urandom_range(0, 31);
      any = 1'($urandom_range(0, 1));
      fill_random(b, n);
      run_req(any, b, n, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ph[i] = 0; pt[i] = '0; pv[i] = '0;
    end
    test_reset();
    test_closest();
    test_any_hit();
    test_empty_miss();
    test_wrap_negative();
    test_backpressure();
    test_reset_mid_issue();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aabb_leaf_scheduler.md
Name: aabb_leaf_scheduler

Overview:
- Sequences one shared AABB-hit datapath over the primitive list of a BVH leaf for a single ray.
- Issues one primitive-memory read per cycle and evaluates the hit-unit result one cycle later.
- Tracks the closest hit, or stops at the first hit in any-hit (shadow) mode, and returns the result over a valid/ready handshake.
- Sits between the BVH traversal unit (requester) and the primitive memory plus the hit datapath.

Parameters:
- IDX_W, 10, primitive memory address width.
- CNT_W, 5, leaf primitive-count width (max leaf size 2^CNT_W-1).
- T_W, 32, hit distance width; two's-complement fixed point, same format as the codebase Fixed type.
- VI_W, 16, voxel index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  leaf request valid.
- req_ready  out  1  scheduler can accept a request.
- req_any_hit  in  1  1 = stop at first hit (shadow ray).
- req_base  in  IDX_W  address of first primitive in leaf.
- req_count  in  CNT_W  number of primitives in leaf.
- mem_rd_en  out  1  primitive memory read strobe.
- mem_rd_addr  out  IDX_W  primitive memory read address.
- hu_hit  in  1  hit-unit hit flag for the primitive read in the previous cycle.
- hu_t  in  T_W  hit-unit hit distance.
- hu_vi  in  VI_W  hit-unit voxel index.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_hit  out  1  any primitive hit.
- res_t  out  T_W  closest (or first, in any-hit mode) hit distance.
- res_vi  out  VI_W  voxel index of that hit.

Behaviour:
- Clock, reset and ray stability:
  - All state is on posedge clk; resetn is asynchronous active-low.
  - The requester holds the ray stable on the hit datapath from request acceptance until the result handshake. The block does not latch the ray.
- Reset values: state=IDLE, req_ready=1, mem_rd_en=0, mem_rd_addr=0, res_valid=0, res_hit=0, res_t=0, res_vi=0; internal best_valid=0, in-flight flag pend=0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch any_hit, addr=req_base, remaining=req_count, clear best_valid. If req_count==0 go to DONE, else go to ISSUE.
  - ISSUE: mem_rd_en=1, mem_rd_addr=addr. Each cycle: addr+1, remaining-1, pend<=1. When remaining==1, the issue is the last one; go to DRAIN.
  - DRAIN: mem_rd_en=0. Evaluates the final in-flight result, then goes to DONE.
  - DONE: res_valid=1. Holds res_* stable until res_ready. Then res_valid<=0 and go to IDLE.
  - req_ready=0 in every state except IDLE.
- Evaluation (ISSUE and DRAIN, whenever pend==1), using the result from the previous cycle's read:
  - If hu_hit && (!best_valid || hu_t < best_t), with a signed compare: best<=(hu_t, hu_vi) and best_valid<=1.
  - Ties keep the earlier primitive (strict less-than).
- Any-hit mode: on the first evaluated hu_hit=1, capture it and go directly to DONE.
  - The read issued in that same cycle is discarded; its result is never evaluated.
  - No further reads are issued.
- DONE outputs: res_hit=best_valid, res_t=best_t, res_vi=best_vi. With no hit: res_hit=0, res_t=0, res_vi=0.
- Latency (closest mode): N primitives give a result in N+2 cycles after acceptance; res_valid is high in cycle N+2. For count==0, res_valid is high 1 cycle after acceptance.
- Throughput: one primitive per cycle while in ISSUE. No bubbles.
- Address wrap: addr increments modulo 2^IDX_W. A base near the top wraps to 0 with no error flag.
- Back-to-back requests: a new request is accepted only in IDLE, i.e. at the earliest 1 cycle after the res handshake.
- hu_* inputs are ignored whenever pend==0 or in IDLE/DONE.
- Asynchronous reset mid-operation: immediately returns to reset values. Any in-flight read and partial result are dropped.

Test Plan:
- Closest hit: base=0x010, count=4, hit unit returns hits (t=5.0,vi=7), miss, (t=2.0,vi=9), (t=2.0,vi=11) -> reads at 0x010..0x013 on 4 consecutive cycles; res_valid on cycle 6; res_hit=1, res_t=2.0, res_vi=9.
- Any-hit: count=6, first hit on the 2nd primitive (t=3.0,vi=4) -> exactly 3 reads issued, 3rd result ignored, res_hit=1, res_t=3.0, res_vi=4.
- Empty and miss: count=0 -> no mem_rd_en, res_valid 1 cycle after acceptance, res_hit=0. Separately, count=3 all misses -> res_hit=0, res_t=0, res_vi=0.
- Negative t and wrap: base=0x3FE, count=3, hits t=-1.0 then t=+0.5 -> addresses 0x3FE, 0x3FF, 0x000; res_t=-1.0 (signed compare).
- Backpressure: res_ready low for 5 cycles -> res_* stable, req_ready=0; the next request is accepted the cycle after the handshake completes.
- Reset mid-ISSUE: drop resetn during the 2nd read -> all outputs at reset values asynchronously; after release, a new count=1 request completes normally.
